// File: rtl/dmem_target_if.sv
// Request/response bus between the pipeline's memory stage and dmem_target.
// The initiator drives the request fields and rsp_ready; the target drives the rest.
interface dmem_target_if #(
  parameter int ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [3:0]        req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_target.sv
// Data-memory responder with a fixed number of wait states.
// A request is latched in IDLE, counted down in WAIT, and the array access
// happens on the edge that enters RESP, where the response is held until taken.
module dmem_target #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int WAIT   = 2
) (
  input  logic         clk,
  input  logic         reset,
  dmem_target_if.slave bus,
  output logic         busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              access;
  logic              rsp_done;
  logic              be_ok;
  logic              addr_ok;
  logic              access_ok;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       lane_mask;

  assign addr_ok   = 32'(addr_q) < 32'(DEPTH);
  assign access_ok = be_ok && addr_ok;
  assign idx       = addr_q[IDX_W-1:0];
  assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

  // Only single bytes, aligned halfwords and full words are legal lane patterns
  always_comb begin
    be_ok = 1'b0;
    case (be_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
  end

  // Next-state logic and handshake outputs; req_ready is forced low while reset is held
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    access        = 1'b0;
    rsp_done      = 1'b0;
    bus.req_ready = reset && (state == S_IDLE);
    bus.rsp_valid = (state == S_RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (bus.req_valid && reset) begin
          accept    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, wait counter, latched request and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= bus.req_we;
        be_q    <= bus.req_be;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt     <= 4'(WAIT);
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err_q   <= !access_ok;
        rdata_q <= (!we_q && access_ok) ? (mem[idx] & lane_mask) : 32'd0;
      end else if (rsp_done) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // Word array without reset; a store writes only its enabled lanes
  always_ff @(posedge clk) begin
    if (reset && access && we_q && access_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_target.sv
// Bench for dmem_target: dut_a (WAIT=2, DEPTH=1024) and dut_b (WAIT=0, DEPTH=512).
// Stimulus pushes expected responses into per-target queues; a monitor pops
// and compares each response when it is handed over.
`timescale 1ns/1ps
module tb_dmem_target;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  rsp_t exp_q0[$];
  rsp_t exp_q1[$];

  logic        req_valid_d [2];
  logic        req_we_d    [2];
  logic [3:0]  req_be_d    [2];
  logic [9:0]  req_addr_d  [2];
  logic [31:0] req_wdata_d [2];
  logic        rsp_ready_d [2];
  logic        req_ready_m [2];
  logic        rsp_valid_m [2];
  logic [31:0] rsp_rdata_m [2];
  logic        rsp_err_m   [2];
  logic        busy_m      [2];
  logic        busy_a;
  logic        busy_b;

  dmem_target_if #(.ADDR_W(10)) bus_a ();
  dmem_target_if #(.ADDR_W(10)) bus_b ();

  assign bus_a.req_valid = req_valid_d[0];
  assign bus_a.req_we    = req_we_d[0];
  assign bus_a.req_be    = req_be_d[0];
  assign bus_a.req_addr  = req_addr_d[0];
  assign bus_a.req_wdata = req_wdata_d[0];
  assign bus_a.rsp_ready = rsp_ready_d[0];
  assign bus_b.req_valid = req_valid_d[1];
  assign bus_b.req_we    = req_we_d[1];
  assign bus_b.req_be    = req_be_d[1];
  assign bus_b.req_addr  = req_addr_d[1];
  assign bus_b.req_wdata = req_wdata_d[1];
  assign bus_b.rsp_ready = rsp_ready_d[1];

  assign req_ready_m[0] = bus_a.req_ready;
  assign rsp_valid_m[0] = bus_a.rsp_valid;
  assign rsp_rdata_m[0] = bus_a.rsp_rdata;
  assign rsp_err_m[0]   = bus_a.rsp_err;
  assign busy_m[0]      = busy_a;
  assign req_ready_m[1] = bus_b.req_ready;
  assign rsp_valid_m[1] = bus_b.rsp_valid;
  assign rsp_rdata_m[1] = bus_b.rsp_rdata;
  assign rsp_err_m[1]   = bus_b.rsp_err;
  assign busy_m[1]      = busy_b;

  dmem_target #(.ADDR_W(10), .DEPTH(1024), .WAIT(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a),
    .busy  (busy_a)
  );

  dmem_target #(.ADDR_W(10), .DEPTH(512), .WAIT(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b),
    .busy  (busy_b)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: timed out, required a handshake", name);
  endtask

  // Issue one request; returns the cycle number of the accepting edge
  task automatic applyStimulus(input int sel, input logic we, input logic [3:0] be,
                               input logic [9:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input bit expect_rsp, output int acc_cyc);
    int   guard;
    rsp_t e;
    guard   = 0;
    acc_cyc = -1;
    while (!req_ready_m[sel]) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 40) begin
        timeoutFail($sformatf("req_accept dut%0d", sel));
        return;
      end
    end
    req_valid_d[sel] = 1'b1;
    req_we_d[sel]    = we;
    req_be_d[sel]    = be;
    req_addr_d[sel]  = addr;
    req_wdata_d[sel] = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    if (expect_rsp) begin
      if (sel == 0) exp_q0.push_back(e);
      else          exp_q1.push_back(e);
    end
    @(posedge clk);
    acc_cyc = cyc + 1;
    #1;
    req_valid_d[sel] = 1'b0;
    req_we_d[sel]    = 1'($urandom_range(1, 0));
    req_be_d[sel]    = 4'($urandom);
    req_addr_d[sel]  = 10'($urandom);
    req_wdata_d[sel] = $urandom;
  endtask

  // Measure latency to rsp_valid, then confirm the return to IDLE after the handshake
  task automatic waitResponse(input int sel, input int exp_lat, input string name);
    int n;
    n = 0;
    while (!rsp_valid_m[sel]) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 40) begin
        timeoutFail({name, " rsp_valid"});
        return;
      end
    end
    checkOutput({name, " latency"}, 32'(n), 32'(exp_lat));
    @(posedge clk);
    #1;
    checkOutput({name, " rsp_valid after handshake"}, 32'(rsp_valid_m[sel]), 32'd0);
    checkOutput({name, " req_ready after handshake"}, 32'(req_ready_m[sel]), 32'd1);
  endtask

  // Monitor: compare every handed-over response against the queued expectation
  always @(negedge clk) begin
    rsp_t e;
    for (int s = 0; s < 2; s++) begin
      if (reset && rsp_valid_m[s] && rsp_ready_d[s]) begin
        if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_rsp dut%0d: got rdata 0x%08h err %0b, required no response",
                   s, rsp_rdata_m[s], rsp_err_m[s]);
        end else begin
          if (s == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          checkOutput($sformatf("rsp_rdata dut%0d", s), rsp_rdata_m[s], e.rdata);
          checkOutput($sformatf("rsp_err dut%0d", s), 32'(rsp_err_m[s]), 32'(e.err));
        end
      end
    end
  end

  // Hard stop in case a wait escapes its bound
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int c0;
    int c1;
    int c2;
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid_d[s] = 1'b1;
      req_we_d[s]    = 1'b0;
      req_be_d[s]    = 4'hF;
      req_addr_d[s]  = 10'd0;
      req_wdata_d[s] = 32'd0;
      rsp_ready_d[s] = 1'b1;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("reset req_ready dut%0d", s), 32'(req_ready_m[s]), 32'd0);
      checkOutput($sformatf("reset rsp_valid dut%0d", s), 32'(rsp_valid_m[s]), 32'd0);
      checkOutput($sformatf("reset busy dut%0d", s), 32'(busy_m[s]), 32'd0);
      checkOutput($sformatf("reset rsp_rdata dut%0d", s), rsp_rdata_m[s], 32'd0);
      checkOutput($sformatf("reset rsp_err dut%0d", s), 32'(rsp_err_m[s]), 32'd0);
    end
    req_valid_d[0] = 1'b0;
    req_valid_d[1] = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("release req_ready dut0", 32'(req_ready_m[0]), 32'd1);
    checkOutput("release req_ready dut1", 32'(req_ready_m[1]), 32'd1);

    applyStimulus(0, 1'b1, 4'b1111, 10'd5, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, c0);
    waitResponse(0, 3, "store5");
    applyStimulus(0, 1'b0, 4'b1111, 10'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, c0);
    waitResponse(0, 3, "load5");
    applyStimulus(0, 1'b1, 4'b0010, 10'd5, 32'h0000AA00, 32'h0, 1'b0, 1'b1, c0);
    waitResponse(0, 3, "store5_lane1");
    applyStimulus(0, 1'b0, 4'b1111, 10'd5, 32'h0, 32'hDEADAAEF, 1'b0, 1'b1, c0);
    waitResponse(0, 3, "load5_word");
    applyStimulus(0, 1'b0, 4'b1100, 10'd5, 32'h0, 32'hDEAD0000, 1'b0, 1'b1, c0);
    waitResponse(0, 3, "load5_hi");
    applyStimulus(0, 1'b0, 4'b0011, 10'd5, 32'h0, 32'h0000AAEF, 1'b0, 1'b1, c0);
    waitResponse(0, 3, "load5_lo");
    applyStimulus(0, 1'b0, 4'b0001, 10'd5, 32'h0, 32'h000000EF, 1'b0, 1'b1, c0);
    waitResponse(0, 3, "load5_b0");

    applyStimulus(0, 1'b1, 4'b1111, 10'd7, 32'h77777777, 32'h0, 1'b0, 1'b1, c0);
    waitResponse(0, 3, "store7");
    applyStimulus(0, 1'b1, 4'b0101, 10'd7, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, c0);
    waitResponse(0, 3, "store7_bad_be");
    applyStimulus(0, 1'b1, 4'b0110, 10'd7, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, c0);
    waitResponse(0, 3, "store7_misaligned");
    applyStimulus(0, 1'b0, 4'b0101, 10'd7, 32'h0, 32'h0, 1'b1, 1'b1, c0);
    waitResponse(0, 3, "load7_bad_be");
    applyStimulus(0, 1'b0, 4'b1111, 10'd7, 32'h0, 32'h77777777, 1'b0, 1'b1, c0);
    waitResponse(0, 3, "load7_unchanged");

    applyStimulus(1, 1'b1, 4'b1111, 10'd1023, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1, c0);
    waitResponse(1, 1, "b_store1023");
    applyStimulus(1, 1'b1, 4'b1111, 10'd511, 32'h0BADF00D, 32'h0, 1'b0, 1'b1, c0);
    waitResponse(1, 1, "b_store511");
    applyStimulus(1, 1'b0, 4'b1111, 10'd511, 32'h0, 32'h0BADF00D, 1'b0, 1'b1, c0);
    waitResponse(1, 1, "b_load511");
    applyStimulus(1, 1'b0, 4'b1111, 10'd512, 32'h0, 32'h0, 1'b1, 1'b1, c0);
    waitResponse(1, 1, "b_load512");

    rsp_ready_d[0] = 1'b0;
    applyStimulus(0, 1'b0, 4'b1111, 10'd5, 32'h0, 32'hDEADAAEF, 1'b0, 1'b1, c0);
    repeat (3) @(posedge clk);
    #1;
    req_valid_d[0] = 1'b1;
    req_we_d[0]    = 1'b1;
    req_be_d[0]    = 4'b1111;
    req_addr_d[0]  = 10'd7;
    req_wdata_d[0] = 32'h5A5A5A5A;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("stall%0d rsp_valid", i), 32'(rsp_valid_m[0]), 32'd1);
      checkOutput($sformatf("stall%0d rsp_rdata", i), rsp_rdata_m[0], 32'hDEADAAEF);
      checkOutput($sformatf("stall%0d rsp_err", i), 32'(rsp_err_m[0]), 32'd0);
      checkOutput($sformatf("stall%0d req_ready", i), 32'(req_ready_m[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    req_valid_d[0] = 1'b0;
    rsp_ready_d[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("stall release rsp_valid", 32'(rsp_valid_m[0]), 32'd0);
    checkOutput("stall release req_ready", 32'(req_ready_m[0]), 32'd1);
    checkOutput("stall release busy", 32'(busy_m[0]), 32'd0);
    applyStimulus(0, 1'b0, 4'b1111, 10'd7, 32'h0, 32'h77777777, 1'b0, 1'b1, c0);
    waitResponse(0, 3, "load7_after_stall");

    applyStimulus(0, 1'b1, 4'b1111, 10'd9, 32'h11111111, 32'h0, 1'b0, 1'b1, c0);
    waitResponse(0, 3, "store9");
    applyStimulus(0, 1'b1, 4'b1111, 10'd9, 32'h22222222, 32'h0, 1'b0, 1'b0, c0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midwait reset busy", 32'(busy_m[0]), 32'd0);
    checkOutput("midwait reset rsp_valid", 32'(rsp_valid_m[0]), 32'd0);
    checkOutput("midwait reset req_ready", 32'(req_ready_m[0]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("post_reset%0d rsp_valid", i), 32'(rsp_valid_m[0]), 32'd0);
    end
    applyStimulus(0, 1'b0, 4'b1111, 10'd9, 32'h0, 32'h11111111, 1'b0, 1'b1, c0);
    waitResponse(0, 3, "load9_after_abort");

    applyStimulus(1, 1'b1, 4'b1111, 10'd3, 32'h12345678, 32'h0, 1'b0, 1'b1, c0);
    applyStimulus(1, 1'b0, 4'b1111, 10'd3, 32'h0, 32'h12345678, 1'b0, 1'b1, c1);
    applyStimulus(1, 1'b0, 4'b0100, 10'd3, 32'h0, 32'h00340000, 1'b0, 1'b1, c2);
    checkOutput("b2b period 1", 32'(c1 - c0), 32'd3);
    checkOutput("b2b period 2", 32'(c2 - c1), 32'd3);
    waitResponse(1, 1, "b2b_last");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("pending rsp dut0", 32'(exp_q0.size()), 32'd0);
    checkOutput("pending rsp dut1", 32'(exp_q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
